dma_segment_scheduler: RTL and testbench
========================================

# dma_segment_scheduler

Sequences DMA write traffic for the four-segment loopback design. Sits between the MMIO memory map, which supplies the four segment base addresses, the per-segment length and `go`, and the DMA write channel. On `go` it interleaves cacheline writes round-robin across segments 0–3 and pops one source word per write. It reports `done` after every issued write has completed, and returns a cycle count through `cv_value`.

## Interface
- `ADDR_WIDTH`, 64: width of the virtual byte addresses and of `cv_value`.
- `SIZE_WIDTH`, 16: width of the per-segment cacheline count.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous and active-high.
- `go` in 1: single-cycle start pulse.
- `size` in SIZE_WIDTH: cachelines per segment; latched on accepted `go`.
- `wr_addr_s0`..`wr_addr_s3` in ADDR_WIDTH each: segment base byte addresses; latched on accepted `go`.
- `src_valid` in 1: the first-word-fall-through (FWFT) source has a cacheline available.
- `src_rd` out 1: pop one source cacheline.
- `dma_wr_en` out 1: issue one cacheline write.
- `dma_wr_addr` out ADDR_WIDTH: byte address for the write.
- `dma_wr_full` in 1: write channel backpressure.
- `dma_wr_cmpl` in 1: one write completed, one pulse per write.
- `done` out 1: transfer complete; held until the next accepted `go`.
- `cv_value` out ADDR_WIDTH: cycles from accepted `go` to `done`.

## Operation
- States: IDLE, ACTIVE, DRAIN, DONE.
- Reset values: state=IDLE, `done`=0, `cv_value`=0, all counters 0.
- **Accepting `go`:** `go` is accepted only in IDLE or DONE. An accepted `go` does the following:
  - latches `size` and the four bases;
  - clears the issue counter, completion counter and `cv_value`;
  - clears `done`.
- **Ignored `go`:** `go` is ignored in ACTIVE and DRAIN.
- **Zero size:** accepted `go` with `size`==0 goes directly to DONE; `cv_value`=1.
- **Issue condition:** `dma_wr_en` = (state==ACTIVE) && `src_valid` && !`dma_wr_full`. `src_rd` equals `dma_wr_en` in the same cycle.
- **Issue counter:** SIZE_WIDTH+2 bits.
  - Low 2 bits select the segment.
  - Upper bits are the line index within the segment.
  - `dma_wr_addr` = base[seg] + line_index*64. Arithmetic is ADDR_WIDTH bits, modulo 2^ADDR_WIDTH; wrap is not checked.
- **Issue order:** s0 line0, s1 line0, s2 line0, s3 line0, s0 line1, and so on.
- **ACTIVE→DRAIN:** on the cycle that issues write number 4*size−1 (the last write).
- **Completion counting:** `dma_wr_cmpl` is counted in ACTIVE and DRAIN and ignored in IDLE and DONE.
- **DRAIN→DONE:** when completions reach 4*size. A completion in the current cycle is included, so the last completion moves the state to DONE on the next edge.
- **`cv_value`:** increments every cycle in ACTIVE and DRAIN; frozen in DONE.
- **Reset mid-operation:** returns everything to reset values. Completions that arrive later in IDLE are dropped.

## Timing
- **Start:** `go` at edge N gives state=ACTIVE and `done`=0 from N+1. The first `dma_wr_en` can occur in cycle N+1.
- **Issue:** zero-latency, combinational from `src_valid` and `dma_wr_full`.
  - Sustained throughput is 1 write/cycle.
  - No bubble at segment rotation or at the ACTIVE→DRAIN transition.
- **Done:** last completion sampled at edge M gives `done`=1 from M+1, held until the next accepted `go`.
- **Simultaneous events:** a completion in the same cycle as the final issue is counted.
- **Race-free by construction:** completions never exceed issues, so DONE cannot be reached from ACTIVE.
- **Restart:** `go` in DONE restarts in one cycle.
- **Registered outputs:** `done` and `cv_value`. **Combinational outputs:** `dma_wr_en`, `src_rd`, `dma_wr_addr`.

## Structure
- Package `dma_sched_pkg`:
  - `state_t` enum (IDLE, ACTIVE, DRAIN, DONE);
  - `CL_BYTES`=64, `CL_SHIFT`=6;
  - `NUM_SEGS`=4.
- No sub-module. The FSM, counters and address mux fit one module of about 150–200 lines.

## Test plan
- **Basic run:** bases 0x1000/0x2000/0x3000/0x4000, size=2, `src_valid`=1, no backpressure, completions 3 cycles after each issue.
  - Expect addresses 0x1000, 0x2000, 0x3000, 0x4000, 0x1040, 0x2040, 0x3040, 0x4040 on consecutive cycles.
  - Expect `done` one cycle after the 8th completion.
  - Expect `cv_value` = cycles from `go` to `done`.
- **Backpressure:** size=1, `dma_wr_full` high for cycles 2–4.
  - Expect no `dma_wr_en` or `src_rd` during those cycles.
  - Expect issue order unchanged and a total of 4 writes.
- **Zero size:** size=0 `go`.
  - Expect `done`=1 next cycle, `cv_value`=1, no `dma_wr_en`.
- **Go while busy:** `go` re-pulsed during ACTIVE with new bases.
  - Expect it ignored and the original addresses continuing.
  - A second `go` in DONE restarts with new bases and clears `done`.
- **Reset mid-operation:** `rst` after 3 of 8 issues.
  - Expect IDLE, `done`=0, `cv_value`=0 next cycle.
  - Late completions must not make `done` rise.
- **Completion sampling:** completions arrive at the same cycle as the final issue, and completions overlap with issues.
  - Expect the completion count to equal 4*size exactly, with `done` asserted once.

Source files
------------

// File: rtl/dma_sched_pkg.sv
// Shared types and constants for the DMA segment scheduler.
// Four segments are interleaved one cacheline at a time.
package dma_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StDrain,
    StDone
  } state_t;

  localparam int unsigned CL_BYTES = 64;
  localparam int unsigned CL_SHIFT = 6;
  localparam int unsigned NUM_SEGS = 4;

endpackage

// File: rtl/dma_segment_scheduler.sv
// Issues cacheline writes round-robin across four segments, one source pop per write,
// then waits for every completion before raising done and freezing the cycle count.
module dma_segment_scheduler
  import dma_sched_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned SIZE_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [SIZE_WIDTH-1:0] size,
  input  logic [ADDR_WIDTH-1:0] wr_addr_s0,
  input  logic [ADDR_WIDTH-1:0] wr_addr_s1,
  input  logic [ADDR_WIDTH-1:0] wr_addr_s2,
  input  logic [ADDR_WIDTH-1:0] wr_addr_s3,
  input  logic                  src_valid,
  output logic                  src_rd,
  output logic                  dma_wr_en,
  output logic [ADDR_WIDTH-1:0] dma_wr_addr,
  input  logic                  dma_wr_full,
  input  logic                  dma_wr_cmpl,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] cv_value
);

  // Two extra bits: the low pair picks the segment, the rest is the line index.
  localparam int unsigned CntWidth = SIZE_WIDTH + 2;

  state_t                state_q, state_d;
  logic [SIZE_WIDTH-1:0] size_q;
  logic [ADDR_WIDTH-1:0] base_q [NUM_SEGS];
  logic [CntWidth-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CntWidth-1:0]   cmpl_cnt_q, cmpl_cnt_d;
  logic [CntWidth-1:0]   total_lines;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] cv_q, cv_d;

  logic                  go_accept;
  logic                  last_issue;
  logic                  cmpl_take;
  logic [1:0]            seg;
  logic [SIZE_WIDTH-1:0] line_idx;

  assign total_lines = {size_q, 2'b00};
  assign seg         = issue_cnt_q[1:0];
  assign line_idx    = issue_cnt_q[CntWidth-1:2];

  always_comb begin
    go_accept   = go && ((state_q == StIdle) || (state_q == StDone));
    dma_wr_en   = (state_q == StActive) && src_valid && !dma_wr_full;
    src_rd      = dma_wr_en;
    dma_wr_addr = base_q[seg] + (ADDR_WIDTH'(line_idx) << CL_SHIFT);
    last_issue  = dma_wr_en && (issue_cnt_q == total_lines - CntWidth'(1));
    cmpl_take   = dma_wr_cmpl && ((state_q == StActive) || (state_q == StDrain));
  end

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    cmpl_cnt_d  = cmpl_cnt_q + CntWidth'(cmpl_take);
    done_d      = done_q;
    cv_d        = cv_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (go_accept) begin
          issue_cnt_d = '0;
          cmpl_cnt_d  = '0;
          if (size == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
            cv_d    = ADDR_WIDTH'(1);
          end else begin
            state_d = StActive;
            done_d  = 1'b0;
            cv_d    = '0;
          end
        end
      end
      StActive: begin
        cv_d = cv_q + ADDR_WIDTH'(1);
        if (dma_wr_en) begin
          issue_cnt_d = issue_cnt_q + CntWidth'(1);
          if (last_issue) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        cv_d = cv_q + ADDR_WIDTH'(1);
        // cmpl_cnt_d already includes a completion arriving this cycle.
        if (cmpl_cnt_d >= total_lines) begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      size_q      <= '0;
      base_q      <= '{default: '0};
      issue_cnt_q <= '0;
      cmpl_cnt_q  <= '0;
      done_q      <= 1'b0;
      cv_q        <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      cmpl_cnt_q  <= cmpl_cnt_d;
      done_q      <= done_d;
      cv_q        <= cv_d;
      if (go_accept) begin
        size_q    <= size;
        base_q[0] <= wr_addr_s0;
        base_q[1] <= wr_addr_s1;
        base_q[2] <= wr_addr_s2;
        base_q[3] <= wr_addr_s3;
      end
    end
  end

  assign done     = done_q;
  assign cv_value = cv_q;

endmodule

// File: tb/tb_dma_segment_scheduler.sv
// Bench for dma_segment_scheduler: scripted and randomized transfers checked against
// an address/timing model derived from segment bases, size and observed events.
module tb_dma_segment_scheduler;

  localparam int unsigned AW = 64;
  localparam int unsigned SW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic [SW-1:0] size;
  logic [AW-1:0] base [4];
  logic          src_valid;
  logic          src_rd;
  logic          dma_wr_en;
  logic [AW-1:0] dma_wr_addr;
  logic          dma_wr_full;
  logic          dma_wr_cmpl;
  logic          done;
  logic [AW-1:0] cv_value;

  dma_segment_scheduler #(.ADDR_WIDTH(AW), .SIZE_WIDTH(SW)) dut (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .size        (size),
    .wr_addr_s0  (base[0]),
    .wr_addr_s1  (base[1]),
    .wr_addr_s2  (base[2]),
    .wr_addr_s3  (base[3]),
    .src_valid   (src_valid),
    .src_rd      (src_rd),
    .dma_wr_en   (dma_wr_en),
    .dma_wr_addr (dma_wr_addr),
    .dma_wr_full (dma_wr_full),
    .dma_wr_cmpl (dma_wr_cmpl),
    .done        (done),
    .cv_value    (cv_value)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Environment state
  int            cyc = 0;
  int            cmpl_pend [$];
  logic [AW-1:0] issued [$];
  int            issue_cyc [$];
  int            dly_min = 3, dly_max = 3;
  bit            rand_mode = 0;
  int            valid_pct = 100, full_pct = 0;
  int            last_cmpl_cyc = 0;
  int            done_cyc = 0, done_rises = 0, go_cyc = 0;
  bit            done_prev = 0;
  int            en_while_full = 0, rd_mismatch = 0;
  logic [AW-1:0] mb [4];

  function automatic logic [AW-1:0] exp_addr(input int k);
    return mb[k % 4] + 64'(k / 4) * 64'd64;
  endfunction

  // One clock: drive completions after the edge, record DUT outputs at the falling edge.
  task automatic step();
    int due;
    @(posedge clk);
    cyc++;
    #1;
    dma_wr_cmpl = 1'b0;
    if (cmpl_pend.size() > 0 && cmpl_pend[0] <= cyc) begin
      void'(cmpl_pend.pop_front());
      dma_wr_cmpl   = 1'b1;
      last_cmpl_cyc = cyc;
    end
    if (rand_mode) begin
      src_valid   = ($urandom_range(99) < valid_pct);
      dma_wr_full = ($urandom_range(99) < full_pct);
    end
    @(negedge clk);
    if (dma_wr_en === 1'b1) begin
      issued.push_back(dma_wr_addr);
      issue_cyc.push_back(cyc);
      due = cyc + dly_min + ((dly_max > dly_min) ? int'($urandom_range(dly_max - dly_min)) : 0);
      if (cmpl_pend.size() > 0 && due <= cmpl_pend[$]) due = cmpl_pend[$] + 1;
      cmpl_pend.push_back(due);
      if (dma_wr_full === 1'b1) en_while_full++;
    end
    if (src_rd !== dma_wr_en) rd_mismatch++;
    if (done === 1'b1 && !done_prev) begin
      done_rises++;
      done_cyc = cyc;
    end
    done_prev = (done === 1'b1);
  endtask

  task automatic settle();
    src_valid   = 1'b0;
    dma_wr_full = 1'b0;
    rand_mode   = 0;
    for (int i = 0; i < 200 && cmpl_pend.size() > 0; i++) step();
    step();
    issued.delete();
    issue_cyc.delete();
    done_rises    = 0;
    en_while_full = 0;
    rd_mismatch   = 0;
  endtask

  task automatic pulse_go(input logic [SW-1:0] sz);
    size = sz;
    go   = 1'b1;
    step();
    go     = 1'b0;
    go_cyc = cyc;
  endtask

  task automatic run_until_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    src_valid = 1'b1;
    step();
    compared++;
    if (done !== 1'b0) begin
      mismatched++; $display("FAIL reset_done: got %0b want 0", done);
    end
    compared++;
    if (cv_value !== 64'd0) begin
      mismatched++; $display("FAIL reset_cv: got %0h want 0", cv_value);
    end
    compared++;
    if (dma_wr_en !== 1'b0) begin
      mismatched++; $display("FAIL reset_idle_en: got %0b want 0", dma_wr_en);
    end
    src_valid = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    settle();
    dly_min = 3; dly_max = 3;
    mb = '{64'h1000, 64'h2000, 64'h3000, 64'h4000};
    base = mb;
    src_valid = 1'b1;
    pulse_go(16'd2);
    compared++;
    if (done !== 1'b0) begin
      mismatched++; $display("FAIL basic_done_cleared: got %0b want 0", done);
    end
    run_until_done(200, ok);
    compared++;
    if (!ok) begin
      mismatched++; $display("FAIL basic_timeout: got done=0 want done=1");
    end
    compared++;
    if (issued.size() != 8) begin
      mismatched++; $display("FAIL basic_count: got %0d want 8", issued.size());
    end
    for (int k = 0; k < issued.size() && k < 8; k++) begin
      compared++;
      if (issued[k] !== exp_addr(k) || issue_cyc[k] != go_cyc + k) begin
        mismatched++;
        $display("FAIL basic_addr%0d: got %0h@%0d want %0h@%0d", k, issued[k], issue_cyc[k],
                 exp_addr(k), go_cyc + k);
      end
    end
    compared++;
    if (done_cyc != last_cmpl_cyc + 1) begin
      mismatched++; $display("FAIL basic_done_time: got %0d want %0d", done_cyc, last_cmpl_cyc + 1);
    end
    compared++;
    if (cv_value !== 64'(done_cyc - go_cyc)) begin
      mismatched++; $display("FAIL basic_cv: got %0d want %0d", cv_value, done_cyc - go_cyc);
    end
    repeat (4) step();
    compared++;
    if (cv_value !== 64'(done_cyc - go_cyc) || done !== 1'b1 || issued.size() != 8) begin
      mismatched++;
      $display("FAIL basic_hold: got cv=%0d done=%0b n=%0d want cv=%0d done=1 n=8", cv_value,
               done, issued.size(), done_cyc - go_cyc);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    settle();
    dly_min = 2; dly_max = 2;
    mb = '{64'h8000, 64'h9000, 64'hA000, 64'hB000};
    base = mb;
    src_valid = 1'b1;
    pulse_go(16'd1);
    dma_wr_full = 1'b1;
    repeat (3) step();
    compared++;
    if (issued.size() != 1 || en_while_full != 0) begin
      mismatched++;
      $display("FAIL bp_stall: got n=%0d en_full=%0d want n=1 en_full=0", issued.size(),
               en_while_full);
    end
    dma_wr_full = 1'b0;
    run_until_done(100, ok);
    compared++;
    if (!ok || issued.size() != 4) begin
      mismatched++; $display("FAIL bp_total: got ok=%0b n=%0d want ok=1 n=4", ok, issued.size());
    end
    for (int k = 0; k < issued.size() && k < 4; k++) begin
      compared++;
      if (issued[k] !== exp_addr(k)) begin
        mismatched++; $display("FAIL bp_addr%0d: got %0h want %0h", k, issued[k], exp_addr(k));
      end
    end
    compared++;
    if (issue_cyc.size() > 1 && issue_cyc[1] != go_cyc + 4) begin
      mismatched++; $display("FAIL bp_resume: got %0d want %0d", issue_cyc[1], go_cyc + 4);
    end
    compared++;
    if (rd_mismatch != 0) begin
      mismatched++; $display("FAIL bp_src_rd: got %0d mismatches want 0", rd_mismatch);
    end
  endtask

  task automatic test_zero_size();
    settle();
    src_valid = 1'b1;
    pulse_go(16'd0);
    compared++;
    if (done !== 1'b1 || cv_value !== 64'd1) begin
      mismatched++; $display("FAIL zero_done: got done=%0b cv=%0d want done=1 cv=1", done, cv_value);
    end
    repeat (3) step();
    compared++;
    if (issued.size() != 0 || done !== 1'b1 || cv_value !== 64'd1) begin
      mismatched++;
      $display("FAIL zero_idle: got n=%0d done=%0b cv=%0d want n=0 done=1 cv=1", issued.size(),
               done, cv_value);
    end
  endtask

  task automatic test_go_while_busy();
    bit ok;
    settle();
    dly_min = 2; dly_max = 4;
    mb = '{64'h10000, 64'h20000, 64'h30000, 64'h40000};
    base = mb;
    src_valid = 1'b1;
    pulse_go(16'd3);
    for (int i = 0; i < 20 && issued.size() < 2; i++) step();
    base = '{64'h5000_0000, 64'h6000_0000, 64'h7000_0000, 64'h8000_0000};
    size = 16'd1;
    go = 1'b1;
    step();
    go = 1'b0;
    run_until_done(200, ok);
    compared++;
    if (!ok || issued.size() != 12) begin
      mismatched++; $display("FAIL busy_count: got ok=%0b n=%0d want ok=1 n=12", ok, issued.size());
    end
    for (int k = 0; k < issued.size() && k < 12; k++) begin
      compared++;
      if (issued[k] !== exp_addr(k)) begin
        mismatched++; $display("FAIL busy_addr%0d: got %0h want %0h", k, issued[k], exp_addr(k));
      end
    end
    compared++;
    if (cv_value !== 64'(done_cyc - go_cyc)) begin
      mismatched++; $display("FAIL busy_cv: got %0d want %0d", cv_value, done_cyc - go_cyc);
    end
    // Restart from DONE with the new bases.
    issued.delete();
    issue_cyc.delete();
    mb = base;
    pulse_go(16'd1);
    compared++;
    if (done !== 1'b0) begin
      mismatched++; $display("FAIL restart_clear: got %0b want 0", done);
    end
    run_until_done(100, ok);
    compared++;
    if (!ok || issued.size() != 4) begin
      mismatched++; $display("FAIL restart_count: got ok=%0b n=%0d want ok=1 n=4", ok, issued.size());
    end
    for (int k = 0; k < issued.size() && k < 4; k++) begin
      compared++;
      if (issued[k] !== exp_addr(k)) begin
        mismatched++; $display("FAIL restart_addr%0d: got %0h want %0h", k, issued[k], exp_addr(k));
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int rises0;
    settle();
    dly_min = 4; dly_max = 4;
    mb = '{64'h100, 64'h200, 64'h300, 64'h400};
    base = mb;
    src_valid = 1'b1;
    pulse_go(16'd2);
    for (int i = 0; i < 20 && issued.size() < 3; i++) step();
    src_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    src_valid = 1'b1;
    compared++;
    if (done !== 1'b0 || cv_value !== 64'd0 || dma_wr_en !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_mid: got done=%0b cv=%0d en=%0b want 0/0/0", done, cv_value, dma_wr_en);
    end
    rises0 = done_rises;
    for (int i = 0; i < 10; i++) step();
    compared++;
    if (done_rises != rises0 || done !== 1'b0 || issued.size() != 3) begin
      mismatched++;
      $display("FAIL rst_late_cmpl: got rises=%0d done=%0b n=%0d want rises=%0d done=0 n=3",
               done_rises, done, issued.size(), rises0);
    end
  endtask

  task automatic test_cmpl_sampling();
    bit ok;
    settle();
    // One-cycle completions land on the final issue cycle and overlap every issue.
    dly_min = 1; dly_max = 1;
    mb = '{64'hC000, 64'hD000, 64'hE000, 64'hF000};
    base = mb;
    src_valid = 1'b1;
    pulse_go(16'd1);
    run_until_done(50, ok);
    compared++;
    if (!ok || done_cyc != go_cyc + 5 || done_cyc != last_cmpl_cyc + 1) begin
      mismatched++;
      $display("FAIL overlap_done: got ok=%0b at %0d want %0d", ok, done_cyc, go_cyc + 5);
    end
    compared++;
    if (cv_value !== 64'd5) begin
      mismatched++; $display("FAIL overlap_cv: got %0d want 5", cv_value);
    end
    repeat (3) step();
    compared++;
    if (done_rises != 1 || issued.size() != 4) begin
      mismatched++;
      $display("FAIL overlap_once: got rises=%0d n=%0d want rises=1 n=4", done_rises, issued.size());
    end
  endtask

  task automatic test_random();
    bit ok;
    int sz, bad;
    for (int it = 0; it < 8; it++) begin
      settle();
      dly_min = 1; dly_max = 6;
      for (int s = 0; s < 4; s++) mb[s] = {$urandom, $urandom};
      if (it == 0) mb[0] = 64'hFFFF_FFFF_FFFF_FF80;
      base = mb;
      sz = $urandom_range(6, 1);
      rand_mode = 1; valid_pct = 70; full_pct = 25;
      pulse_go(16'(sz));
      run_until_done(2000, ok);
      compared++;
      if (!ok || issued.size() != 4 * sz) begin
        mismatched++;
        $display("FAIL rand%0d_count: got ok=%0b n=%0d want ok=1 n=%0d", it, ok, issued.size(),
                 4 * sz);
      end
      bad = 0;
      for (int k = 0; k < issued.size(); k++) begin
        if (issued[k] !== exp_addr(k)) begin
          if (bad == 0)
            $display("FAIL rand%0d_addr%0d: got %0h want %0h", it, k, issued[k], exp_addr(k));
          bad++;
        end
      end
      compared++;
      if (bad != 0) mismatched++;
      compared++;
      if (done_cyc != last_cmpl_cyc + 1 || cv_value !== 64'(done_cyc - go_cyc)) begin
        mismatched++;
        $display("FAIL rand%0d_done: got at=%0d cv=%0d want at=%0d cv=%0d", it, done_cyc, cv_value,
                 last_cmpl_cyc + 1, done_cyc - go_cyc);
      end
      compared++;
      if (en_while_full != 0 || rd_mismatch != 0 || done_rises != 1) begin
        mismatched++;
        $display("FAIL rand%0d_flow: got en_full=%0d rd_mis=%0d rises=%0d want 0/0/1", it,
                 en_while_full, rd_mismatch, done_rises);
      end
    end
    rand_mode = 0;
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; size = '0; src_valid = 1'b0; dma_wr_full = 1'b0; dma_wr_cmpl = 1'b0;
    base = '{default: '0};
    mb   = '{default: '0};
    repeat (2) step();
    test_reset();
    rst = 1'b0;
    test_basic();
    test_backpressure();
    test_zero_size();
    test_go_while_busy();
    test_reset_mid_op();
    test_cmpl_sampling();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
